// File: rtl/mult_div_unit_if.sv
// Handshake/result bundle between the execute stage and mult_div_unit.
// master: execute stage (drives requests). slave: the multiply/divide engine.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic        HI_write_enable;
  logic [31:0] HI_write_data;
  logic        LO_write_enable;
  logic [31:0] LO_write_data;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, HI_write_enable, HI_write_data, LO_write_enable, LO_write_data
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, HI_write_enable, HI_write_data, LO_write_enable, LO_write_data
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine producing HI/LO register write-back.
// Multiply: full 64-bit product, MULT_STAGES cycles from accept to write pulse.
// Divide: radix-2 restoring on magnitudes, 32 iterations plus a sign-fix cycle.
// Optional macro DIV_ZERO_BYPASS_EN: divide by zero skips the iterations and
// goes straight to the fix cycle (same result values, shorter latency).
module mult_div_unit #(
  parameter int MULT_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

`ifdef DIV_ZERO_BYPASS_EN
  localparam bit DIV0_BYPASS = 1'b1;
`else
  localparam bit DIV0_BYPASS = 1'b0;
`endif

  localparam logic [5:0] MUL_LAST = 6'(MULT_STAGES - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state, state_nxt;
  logic        fin;
  logic [5:0]  cnt;
  logic        uns_q;          // MULTU/DIVU
  logic [31:0] a_q, b_q;       // raw latched operands
  logic [31:0] rem, quo, dvs;  // divider working registers (magnitudes)
  logic        neg_q, neg_r;   // quotient / remainder need negation
  logic        done_q;
  logic [31:0] hi_q, lo_q;

  // Request-side sign handling: only signed ops take magnitudes.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign a_neg = ~bus.op[0] & bus.operand_a[31];
  assign b_neg = ~bus.op[0] & bus.operand_b[31];
  assign a_mag = a_neg ? (32'd0 - bus.operand_a) : bus.operand_a;
  assign b_mag = b_neg ? (32'd0 - bus.operand_b) : bus.operand_b;

  // Full product of the latched operands; sign extension to 64 bits makes the
  // truncated 64x64 product correct for both signed and unsigned operands.
  logic [63:0] ext_a, ext_b, prod_c, prod_fin;
  assign ext_a  = uns_q ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
  assign ext_b  = uns_q ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
  assign prod_c = ext_a * ext_b;

  generate
    if (MULT_STAGES == 1) begin : g_nopipe
      assign prod_fin = prod_c;
    end else begin : g_pipe
      logic [MULT_STAGES-1:1][63:0] pipe;
      // Product pipeline; operands stay stable for the whole MUL state.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pipe <= '0;
        end else begin
          pipe[1] <= prod_c;
          for (int k = 2; k < MULT_STAGES; k++) pipe[k] <= pipe[k-1];
        end
      end
      assign prod_fin = pipe[MULT_STAGES-1];
    end
  endgenerate

  // One restoring-division step: shift in next dividend bit, try subtract.
  logic [32:0] r_sh, diff;
  logic [31:0] rem_nxt, quo_nxt;
  always_comb begin
    r_sh = {rem, quo[31]};
    diff = r_sh - {1'b0, dvs};
    if (!diff[32]) begin
      rem_nxt = diff[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end else begin
      rem_nxt = r_sh[31:0];
      quo_nxt = {quo[30:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; fin marks the edge that writes results.
  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        if (!bus.op[1])                           state_nxt = MUL;
        else if (DIV0_BYPASS && bus.operand_b == '0) state_nxt = FIX;
        else                                      state_nxt = DIV;
      end
      MUL: if (cnt == MUL_LAST) begin
        state_nxt = IDLE;
        fin       = 1'b1;
      end
      DIV: if (cnt == DIV_LAST) state_nxt = FIX;
      FIX: begin
        state_nxt = IDLE;
        fin       = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch on accept, iterate, and register results on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      uns_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= fin;
      case (state)
        IDLE: if (bus.start) begin
          cnt   <= '0;
          uns_q <= bus.op[0];
          a_q   <= bus.operand_a;
          b_q   <= bus.operand_b;
          rem   <= '0;
          quo   <= a_mag;
          dvs   <= b_mag;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
        end
        MUL: begin
          cnt <= cnt + 6'd1;
          if (cnt == MUL_LAST) begin
            hi_q <= prod_fin[63:32];
            lo_q <= prod_fin[31:0];
          end
        end
        DIV: begin
          cnt <= cnt + 6'd1;
          rem <= rem_nxt;
          quo <= quo_nxt;
        end
        FIX: begin
          // Divide by zero: HI returns the dividend, LO all ones.
          if (b_q == '0) begin
            hi_q <= a_q;
            lo_q <= '1;
          end else begin
            hi_q <= neg_r ? (32'd0 - rem) : rem;
            lo_q <= neg_q ? (32'd0 - quo) : quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy            = (state != IDLE);
  assign bus.done            = done_q;
  assign bus.HI_write_enable = done_q;
  assign bus.LO_write_enable = done_q;
  assign bus.HI_write_data   = hi_q;
  assign bus.LO_write_data   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus corner-case sequences.
module tb_mult_div_unit;
  localparam int MS      = 2;
  localparam int DIV_LAT = 33;
`ifdef DIV_ZERO_BYPASS_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 33;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if bus();
  mult_div_unit #(.MULT_STAGES(MS)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive a request for one cycle; afterwards scramble the inputs.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 2'($urandom);
    bus.operand_a = $urandom; bus.operand_b = $urandom;
  endtask

  // Count edges after acceptance until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    logic [31:0] hi, lo;
    start_op(v.op, v.a, v.b);
    chk({v.name, " busy"}, 32'(bus.busy), 32'd1);
    wait_done(lat);
    chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
    chk({v.name, " we"}, {30'd0, bus.HI_write_enable, bus.LO_write_enable}, 32'd3);
    chk({v.name, " busy_in_done"}, 32'(bus.busy), 32'd0);
    hi = bus.HI_write_data; lo = bus.LO_write_data;
    chk({v.name, " HI"}, hi, v.hi);
    chk({v.name, " LO"}, lo, v.lo);
    @(posedge clk); #1;
    chk({v.name, " pulse_end"}, 32'(bus.done), 32'd0);
    chk({v.name, " HI_hold"}, bus.HI_write_data, v.hi);
  endtask

  initial begin
    int lat, ndone;
    logic [31:0] hi, lo;

    vecs.push_back('{"multu_3x5",     2'b01, 32'd3,        32'd5,        32'h0,        32'd15,       MS});
    vecs.push_back('{"mult_m1xm1",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        MS});
    vecs.push_back('{"multu_max",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,        MS});
    vecs.push_back('{"mult_min_x2",   2'b00, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h0,        MS});
    vecs.push_back('{"mult_7xm3",     2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, MS});
    vecs.push_back('{"div_m7_2",      2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT});
    vecs.push_back('{"divu_7_2",      2'b11, 32'd7,        32'd2,        32'd1,        32'd3,        DIV_LAT});
    vecs.push_back('{"div_min_m1",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, DIV_LAT});
    vecs.push_back('{"divu_by0",      2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, DIV0_LAT});
    vecs.push_back('{"div_m7_by0",    2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, DIV0_LAT});
    vecs.push_back('{"divu_max_16",   2'b11, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, DIV_LAT});
    vecs.push_back('{"div_7_m2",      2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DIV_LAT});
    vecs.push_back('{"divu_100_7",    2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       DIV_LAT});
    vecs.push_back('{"div_m100_m7",   2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       DIV_LAT});

    bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done_we", {29'd0, bus.done, bus.HI_write_enable, bus.LO_write_enable}, 32'd0);
    chk("rst HI", bus.HI_write_data, 32'd0);
    chk("rst LO", bus.LO_write_data, 32'd0);
    @(negedge clk) reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a divide: outputs clear, no write ever follows.
    start_op(2'b11, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort HI", bus.HI_write_data, 32'd0);
    chk("abort LO", bus.LO_write_data, 32'd0);
    @(negedge clk) reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.HI_write_enable === 1'b1) ndone++;
    end
    chk("abort no_write", 32'(ndone), 32'd0);
    run_vec('{"post_abort_multu", 2'b01, 32'd3, 32'd5, 32'h0, 32'd15, MS});

    // start hammered during a divide with changing operands: one result only.
    start_op(2'b11, 32'd100, 32'd7);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'($urandom);
      bus.operand_a = $urandom; bus.operand_b = $urandom;
    end
    @(negedge clk) bus.start = 1'b0;
    ndone = 0; hi = '0; lo = '0;
    repeat (45) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        ndone++;
        hi = bus.HI_write_data; lo = bus.LO_write_data;
      end
    end
    chk("spam done_count", 32'(ndone), 32'd1);
    chk("spam HI", hi, 32'd2);
    chk("spam LO", lo, 32'd14);

    // Back-to-back: second MULTU issued in the done cycle of the first.
    start_op(2'b01, 32'd3, 32'd5);
    wait_done(lat);
    chk("b2b first_lat", 32'(lat), 32'(MS));
    chk("b2b first_LO", bus.LO_write_data, 32'd15);
    start_op(2'b01, 32'd6, 32'd7);
    chk("b2b accepted", 32'(bus.busy), 32'd1);
    chk("b2b hold_LO", bus.LO_write_data, 32'd15);
    chk("b2b hold_HI", bus.HI_write_data, 32'd0);
    wait_done(lat);
    chk("b2b second_lat", 32'(lat), 32'(MS));
    chk("b2b second_HI", bus.HI_write_data, 32'd0);
    chk("b2b second_LO", bus.LO_write_data, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Multi-cycle integer multiply/divide engine that produces the HI/LO write-back for the register file.
- Accepts one MULT/MULTU/DIV/DIVU operation at a time from the execute stage and signals `busy` so the pipeline can stall `MFHI`/`MFLO`.
- On completion, pulses `HI_write_enable` and `LO_write_enable` together for one cycle, with both results valid.

## Interface

Parameters:
- `MULT_STAGES`, default 2: clock cycles from an accepted multiply to its write pulse. Legal range 1–4.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled on a rising edge only while `busy`=0.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `operand_a`  in  32  rs value: multiplicand or dividend.
- `operand_b`  in  32  rt value: multiplier or divisor.
- `busy`  out  1  operation in flight; a new `start` is ignored.
- `done`  out  1  one-cycle completion pulse.
- `HI_write_enable`  out  1  equals `done`.
- `HI_write_data`  out  32  product[63:32] or remainder.
- `LO_write_enable`  out  1  equals `done`.
- `LO_write_data`  out  32  product[31:0] or quotient.

## Operation

- States: IDLE, MUL, DIV, FIX.
- IDLE + `start` → MUL (op 0x) or DIV (op 1x).
  - Operands and `op` are latched at that edge and may change afterwards.
- MUL:
  - Full 64-bit product: signed for MULT, unsigned for MULTU.
  - Pipelined over `MULT_STAGES` cycles, then → IDLE, asserting `done`.
- DIV:
  - Radix-2 restoring division on magnitudes (DIVU: raw operands), one quotient bit per cycle, 32 iterations, then → FIX.
- FIX:
  - DIV applies sign correction: quotient truncates toward zero; remainder takes the dividend's sign.
  - DIVU passes results through.
  - Then → IDLE, asserting `done`.
- Arithmetic rules:
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0; no trap.
  - Divide by zero (either signedness) gives HI=`operand_a` and LO=0xFFFFFFFF.
- Outputs are registered.
  - `done` and both write enables are high for exactly the one cycle after the final state's edge.
  - `HI_write_data`/`LO_write_data` hold the last result until the next completion.
- `busy` is high in every non-IDLE state. It is low in the `done` cycle, so a back-to-back `start` is accepted then.
- `start` while `busy`=1 is ignored: no queueing, no error.
- Reset (asynchronous, any state):
  - → IDLE; `busy`, `done` and both write enables go to 0; data outputs go to 0.
  - An aborted operation never produces a write pulse.

## Timing

- Start accepted at edge N:
  - `busy`=1 from N.
  - Multiply: `done` high in the cycle after edge N+`MULT_STAGES`.
  - Divide: `done` high in the cycle after edge N+33 (32 iterations + FIX).
- Write pulse is stable for the whole cycle. This satisfies the register file whether it writes on the rising or the falling edge.
- Reset release: first `start` is accepted at the first rising edge after `reset` deasserts.

## Configuration

- `DIV_ZERO_BYPASS_EN`:
  - Defined: DIV/DIVU with `operand_b`=0 goes IDLE → FIX directly; `done` is high in the cycle after edge N+1.
  - Undefined: divide by zero runs the full 33-cycle sequence.
  - Result values (HI=`operand_a`, LO=0xFFFFFFFF) are identical in both builds; only latency differs.

## Test plan

- Reset mid-divide (edge N+10) → `busy`=0 immediately, no write pulse ever. A following MULTU 3×5 → HI=0, LO=15 after `MULT_STAGES`.
- MULT 0xFFFFFFFF×0xFFFFFFFF → HI=0, LO=1. MULTU with the same operands → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF at N+33. DIVU 7/2 → LO=3, HI=1. DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- DIVU 0x1234/0 → HI=0x00001234, LO=0xFFFFFFFF. `done` at N+1 with `DIV_ZERO_BYPASS_EN`, at N+33 without.
- `start` pulsed every cycle during a divide → exactly one `done`. Operands changed after N do not alter the result.
- Back-to-back: new `start` in the `done` cycle of a MULT is accepted. Its write follows `MULT_STAGES` later, and the first result holds until then.
